// File: rtl/target_gen_pkg.sv
// target_gen_pkg -- shared definitions for the random target generator:
// FSM state encoding, LFSR geometry/seed/taps, conversion step count and
// the two small datapath helpers (LFSR step, double-dabble digit adjust).
package target_gen_pkg;

    localparam int               LFSR_W     = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 8'h01;
    // Feedback taps on bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'b1011_1000;
    localparam int               CONV_STEPS = 8;
    localparam int               BCD_W      = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One Fibonacci step: shift left, feed the tap parity into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/target_gen_if.sv
// target_gen_if -- request/acknowledge handshake plus the presented target.
// master: the generator (drives target, digits, valid, busy).
// slave:  the consumer (drives request and acknowledge).
interface target_gen_if;

    logic       tgt_req;
    logic       tgt_ack;
    logic [7:0] tgt_bin;
    logic [3:0] tgt_d0;
    logic [3:0] tgt_d1;
    logic [3:0] tgt_d2;
    logic       tgt_valid;
    logic       busy;

    modport master (
        input  tgt_req, tgt_ack,
        output tgt_bin, tgt_d0, tgt_d1, tgt_d2, tgt_valid, busy
    );

    modport slave (
        output tgt_req, tgt_ack,
        input  tgt_bin, tgt_d0, tgt_d1, tgt_d2, tgt_valid, busy
    );

endinterface

// File: rtl/target_gen_lfsr8.sv
// lfsr8 -- free-running 8-bit Fibonacci LFSR, seeded with 8'h01 on reset.
// Never reaches zero, so it walks all 255 non-zero values.
module lfsr8
    import target_gen_pkg::*;
(
    input  logic              clk50,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_d;
    logic [LFSR_W-1:0] q_q;

    // Next value is one shift of the current one.
    always_comb begin
        q_d = lfsr_step(q_q);
    end

    // State register with synchronous reset to the seed.
    always_ff @(posedge clk50) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/target_gen.sv
// target_gen -- draws a pseudo-random target (1..255) from an LFSR on
// request, converts it to three BCD digits with a serial double-dabble,
// and presents it until acknowledged.
// Optional feature: define TARGET_GEN_NOREPEAT_EN to reject a draw equal to
// the last delivered target (one extra DRAW cycle takes the next LFSR value).
module target_gen
    import target_gen_pkg::*;
(
    input  logic            clk50,
    input  logic            reset,
    target_gen_if.master    bus
);

    logic [LFSR_W-1:0] lfsr_val;

    lfsr8 u_lfsr (
        .clk50 (clk50),
        .reset (reset),
        .q     (lfsr_val)
    );

    state_t            state_d,   state_q;
    logic [7:0]        bin_d,     bin_q;
    logic [7:0]        sr_d,      sr_q;       // binary bits still to shift in
    logic [BCD_W-1:0]  bcd_d,     bcd_q;      // BCD accumulator {d2,d1,d0}
    logic [2:0]        cnt_d,     cnt_q;      // shift counter
    logic              shifted_d, shifted_q;  // all 8 shifts complete
    logic [3:0]        d0_d,      d0_q;
    logic [3:0]        d1_d,      d1_q;
    logic [3:0]        d2_d,      d2_q;
    logic              valid_d,   valid_q;
    logic              busy_d,    busy_q;
    logic [BCD_W+7:0]  dd_shift;

    // Next-state and datapath: capture, shift/adjust, present, release.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        bin_d     = bin_q;
        sr_d      = sr_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        shifted_d = shifted_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        valid_d   = valid_q;
        dd_shift  = {dd_adjust(bcd_q), sr_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (bus.tgt_req) begin
`ifdef TARGET_GEN_NOREPEAT_EN
                    if (lfsr_val == bin_q) begin
                        state_d = ST_DRAW;
                    end else
`endif
                    begin
                        bin_d     = lfsr_val;
                        sr_d      = lfsr_val;
                        bcd_d     = '0;
                        cnt_d     = '0;
                        shifted_d = 1'b0;
                        state_d   = ST_CONV;
                    end
                end
            end

            ST_DRAW: begin
`ifdef TARGET_GEN_NOREPEAT_EN
                // The LFSR has stepped since IDLE, so this value differs.
                bin_d     = lfsr_val;
                sr_d      = lfsr_val;
                bcd_d     = '0;
                cnt_d     = '0;
                shifted_d = 1'b0;
                state_d   = ST_CONV;
`else
                state_d   = ST_IDLE;
`endif
            end

            ST_CONV: begin
                if (!shifted_q) begin
                    bcd_d = dd_shift[BCD_W+7:8];
                    sr_d  = dd_shift[7:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'(CONV_STEPS - 1)) begin
                        shifted_d = 1'b1;
                    end
                end else begin
                    // Extra cycle after the last shift publishes the digits.
                    d2_d    = bcd_q[11:8];
                    d1_d    = bcd_q[7:4];
                    d0_d    = bcd_q[3:0];
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (bus.tgt_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM and output registers; reset aborts any operation in progress.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            sr_q      <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            shifted_q <= 1'b0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            sr_q      <= sr_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            shifted_q <= shifted_d;
            d0_q      <= d0_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tgt_bin   = bin_q;
    assign bus.tgt_d0    = d0_q;
    assign bus.tgt_d1    = d1_q;
    assign bus.tgt_d2    = d2_q;
    assign bus.tgt_valid = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_target_gen.sv
// tb_target_gen -- self-checking bench for target_gen: table-driven capture
// vectors, hold/ack, mid-conversion reset, repeat handling and a full sweep
// of all 255 target values, with a scoreboard queue of expected targets.
module tb_target_gen;

    typedef struct {
        logic [7:0] bin;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        int         lat;
    } exp_t;

    typedef struct {
        int   idle_edges;
        exp_t e;
    } vec_t;

    logic clk50 = 1'b0;
    logic reset = 1'b1;

    always #10 clk50 = ~clk50;

    target_gen_if bus ();

    target_gen dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    exp_t       sb[$];
    logic [7:0] m_lfsr;
    logic [7:0] last_bin;
    logic [11:0] last_dig;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR tracking the DUT's free-running sequence.
    always @(posedge clk50) begin
        if (reset) m_lfsr <= 8'h01;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic exp_t make_exp(input logic [7:0] v, input int lat);
        exp_t e;
        int   n;
        n     = int'(v);
        e.bin = v;
        e.d2  = 4'(n / 100);
        e.d1  = 4'((n / 10) % 10);
        e.d0  = 4'(n % 10);
        e.lat = lat;
        return e;
    endfunction

    // What a request issued now should deliver.
    function automatic exp_t predict();
        logic [7:0] v;
        int         lat;
        v   = m_lfsr;
        lat = 9;
`ifdef TARGET_GEN_NOREPEAT_EN
        if (v == last_bin) begin
            v   = lfsr_next(v);
            lat = 10;
        end
`endif
        return make_exp(v, lat);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk50);
    endtask

    task automatic do_reset();
        bus.tgt_req = 1'b0;
        bus.tgt_ack = 1'b0;
        reset       = 1'b1;
        tick();
        tick();
        check("rst_outputs",
              {10'd0, bus.tgt_bin, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0, bus.tgt_valid, bus.busy},
              32'd0);
        reset    = 1'b0;
        last_bin = 8'h00;
        last_dig = 12'h000;
        sb.delete();
    endtask

    // Request now (DUT idle), wait for valid, compare against the scoreboard.
    task automatic issue(input exp_t e);
        exp_t x;
        int   lat;
        bit   got;
        sb.push_back(e);
        bus.tgt_req = 1'b1;
        tick();
        bus.tgt_req = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (lat == 1) check("busy_after_req", {31'd0, bus.busy}, 32'd1);
            if (lat == 8) begin
                check("digits_hold_conv", {20'd0, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0}, {20'd0, last_dig});
                check("bin_captured", {24'd0, bus.tgt_bin}, {24'd0, e.bin});
            end
            if (bus.tgt_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check("valid_seen", {31'd0, got}, 32'd1);
        if (got) begin
            x = sb.pop_front();
            check("latency", lat, x.lat);
            check("tgt_bin", {24'd0, bus.tgt_bin}, {24'd0, x.bin});
            check("digits", {20'd0, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0}, {20'd0, x.d2, x.d1, x.d0});
            check("busy_done", {31'd0, bus.busy}, 32'd1);
            last_bin = x.bin;
            last_dig = {x.d2, x.d1, x.d0};
        end else begin
            sb.delete();
        end
    endtask

    task automatic ack_round();
        bus.tgt_ack = 1'b1;
        tick();
        bus.tgt_ack = 1'b0;
        check("ack_valid_clr", {31'd0, bus.tgt_valid}, 32'd0);
        check("ack_busy_clr", {31'd0, bus.busy}, 32'd0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[4];
        exp_t       e;
        bit [255:0] seen;
        int         seen_cnt;
        int         n;

        // Capture vectors: idle edges after reset release before the request.
        vecs[0] = '{0, '{8'h01, 4'd0, 4'd0, 4'd1, 9}};
        vecs[1] = '{4, '{8'h11, 4'd0, 4'd1, 4'd7, 9}};
        vecs[2] = '{6, '{8'h47, 4'd0, 4'd7, 4'd1, 9}};
        vecs[3] = '{7, '{8'h8E, 4'd1, 4'd4, 4'd2, 9}};

        bus.tgt_req = 1'b0;
        bus.tgt_ack = 1'b0;

        // Table-driven captures after reset.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            repeat (vecs[i].idle_edges) tick();
            issue(vecs[i].e);
            ack_round();
        end

        // Hold in DONE with ack low and req toggling, then ack+req together.
        do_reset();
        repeat (2) tick();
        e = predict();
        issue(e);
        for (int i = 0; i < 20; i++) begin
            bus.tgt_req = i[0];
            tick();
            check("hold_state",
                  {10'd0, bus.tgt_bin, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0, bus.tgt_valid, bus.busy},
                  {10'd0, e.bin, e.d2, e.d1, e.d0, 1'b1, 1'b1});
        end
        bus.tgt_req = 1'b1;
        bus.tgt_ack = 1'b1;
        tick();
        bus.tgt_req = 1'b0;
        bus.tgt_ack = 1'b0;
        check("ackreq_valid", {31'd0, bus.tgt_valid}, 32'd0);
        check("ackreq_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_new_capture", {23'd0, bus.tgt_bin, bus.busy}, {23'd0, e.bin, 1'b0});
        end
        // Ack alone in IDLE does nothing.
        bus.tgt_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ack_idle_ignored", {30'd0, bus.busy, bus.tgt_valid}, 32'd0);
        end
        bus.tgt_ack = 1'b0;
        issue(predict());
        ack_round();

        // Reset on the 4th conversion cycle aborts everything.
        do_reset();
        repeat (3) tick();
        bus.tgt_req = 1'b1;
        tick();
        bus.tgt_req = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midconv_reset",
              {10'd0, bus.tgt_bin, bus.tgt_d2, bus.tgt_d1, bus.tgt_d0, bus.tgt_valid, bus.busy},
              32'd0);
        reset    = 1'b0;
        last_bin = 8'h00;
        last_dig = 12'h000;
        sb.delete();
        issue('{8'h01, 4'd0, 4'd0, 4'd1, 9});
        ack_round();

        // Request exactly when the LFSR equals the last delivered target.
        do_reset();
        issue(predict());
        ack_round();
        n = 0;
        while (m_lfsr != last_bin && n < 300) begin
            tick();
            n++;
        end
        check("repeat_wait", {31'd0, n < 300}, 32'd1);
        issue(predict());
        ack_round();

        // Sweep every target value 1..255.
        do_reset();
        seen     = '0;
        seen_cnt = 0;
        for (int r = 0; r < 300 && seen_cnt < 255; r++) begin
            n = 0;
            while (seen[predict().bin] && n < 300) begin
                tick();
                n++;
            end
            if (n >= 300) begin
                check("sweep_wait", 32'd0, 32'd1);
                break;
            end
            issue(predict());
            if (bus.tgt_valid === 1'b1 && !seen[bus.tgt_bin]) begin
                seen[bus.tgt_bin] = 1'b1;
                seen_cnt++;
            end
            ack_round();
        end
        check("sweep_count", seen_cnt, 255);
        check("sweep_saw_255", {31'd0, seen[255]}, 32'd1);
        check("sweep_saw_100", {31'd0, seen[100]}, 32'd1);
        check("sweep_never_0", {31'd0, seen[0]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
